// File: rtl/neuron_pkg.sv
// Shared definitions for the fixed-point neuron family: default formats,
// activation selectors, FSM encoding and accumulator width helper.
package neuron_pkg;

  localparam int DEF_WIDTH = 20;
  localparam int DEF_FRAC  = 15;

  localparam int ACT_NONE = 0;
  localparam int ACT_RELU = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Wide enough that bias plus n_in shifted products can never overflow.
  function automatic int acc_w(input int width, input int frac, input int n_in);
    return 2 * width - frac + $clog2(n_in + 1);
  endfunction

endpackage

// File: rtl/neuron_sat_act.sv
// Reduces a wide accumulator to WIDTH bits (saturate or wrap), flags range
// overflow, then optionally applies ReLU. Purely combinational.
module neuron_sat_act
  import neuron_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = acc_w(DEF_WIDTH, DEF_FRAC, 2),
  parameter int SAT   = 1,
  parameter int ACT   = ACT_NONE
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [WIDTH-1:0] z_o,
  output logic                    ovf_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  logic             hi;
  logic             lo;
  logic [WIDTH-1:0] pre;

  always_comb begin
    hi    = (acc_i > MAX_V);
    lo    = (acc_i < MIN_V);
    ovf_o = hi | lo;
    pre   = acc_i[WIDTH-1:0];
    if (SAT != 0) begin
      if (hi) begin
        pre = MAX_V[WIDTH-1:0];
      end else if (lo) begin
        pre = MIN_V[WIDTH-1:0];
      end
    end
    // ReLU looks at the already-reduced value, so ovf is left untouched.
    z_o = pre;
    if ((ACT == ACT_RELU) && pre[WIDTH-1]) begin
      z_o = '0;
    end
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: one shared multiplier, one product per clock,
// result z = act(sat(bias + sum((w_i*a_i) >>> FRAC))).
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int SAT   = 1,
  parameter int ACT   = ACT_NONE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*WIDTH-1:0]  a_flat,
  input  logic [N_IN*WIDTH-1:0]  w_flat,
  input  logic [WIDTH-1:0]       bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       z,
  output logic                   ovf,
  output state_t                 dbg_state
);

  localparam int ACC_W = acc_w(WIDTH, FRAC, N_IN);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  state_t                   state_q;
  logic [N_IN*WIDTH-1:0]    a_q;
  logic [N_IN*WIDTH-1:0]    w_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic [IDX_W-1:0]         idx_q;
  logic                     out_valid_q;
  logic [WIDTH-1:0]         z_q;
  logic                     ovf_q;

  logic signed [WIDTH-1:0]   a_cur;
  logic signed [WIDTH-1:0]   w_cur;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]          z_c;
  logic                      ovf_c;

  always_comb begin
    a_cur = '0;
    w_cur = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_cur = a_q[i*WIDTH +: WIDTH];
        w_cur = w_q[i*WIDTH +: WIDTH];
      end
    end
    prod  = (2*WIDTH)'(a_cur) * (2*WIDTH)'(w_cur);
    acc_d = acc_q + ACC_W'(prod >>> FRAC);
  end

  // Result is reduced from acc_d so z/ovf land on the same edge as the last product.
  neuron_sat_act #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .SAT   (SAT),
    .ACT   (ACT)
  ) u_sat_act (
    .acc_i (acc_d),
    .z_o   (z_c),
    .ovf_o (ovf_c)
  );

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, and z/ovf are
  // held stable for as long as out_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      w_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a_flat;
            w_q     <= w_flat;
            acc_q   <= ACC_W'(signed'(bias));
            idx_q   <= '0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            z_q         <= z_c;
            ovf_q       <= ovf_c;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
